// File: rtl/packet_demux.sv
// Segment demultiplexer: parses headers from a single-word stream and steers payload
// words to per-channel handshakes. Define PACKET_DEMUX_CHECK_EN to enable header validation.
module packet_demux #(
    parameter int                    CHANNEL_COUNT        = 4,
    parameter int                    WORD_SIZE            = 32,
    parameter logic [WORD_SIZE-1:0]  HEADER_TEMPLATE      = WORD_SIZE'(32'h10000000),
    parameter logic [WORD_SIZE-1:0]  HEADER_MASK          = WORD_SIZE'(32'hF0000000),
    parameter int                    HEADER_COUNT_SHIFT   = 0,
    parameter int                    HEADER_CHANNEL_SHIFT = 8,
    parameter int                    HEADER_END_SHIFT     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_nempty,
    output logic                     in_pop,
    input  logic [WORD_SIZE-1:0]     in_data,
    output logic [CHANNEL_COUNT-1:0] out_valid,
    input  logic [CHANNEL_COUNT-1:0] out_ready,
    output logic [CHANNEL_COUNT-1:0] out_end,
    output logic [WORD_SIZE-1:0]     out_data,
    output logic [15:0]              err_count
);

    localparam int CH_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;

    localparam logic STATE_HEADER  = 1'b0;
    localparam logic STATE_PAYLOAD = 1'b1;

    logic            state;
    logic [7:0]      remaining;
    logic [CH_W-1:0] seg_channel;
    logic            seg_end;

    // Output register: one word plus the channel tag it belongs to.
    logic                 reg_valid;
    logic                 reg_end;
    logic [CH_W-1:0]      reg_channel;
    logic [WORD_SIZE-1:0] reg_data;

    logic [7:0] hdr_count;
    logic [7:0] hdr_channel;
    logic       hdr_end;
    logic       hdr_ok;
    logic       reg_free;
    logic       load;

    assign hdr_count   = in_data[HEADER_COUNT_SHIFT +: 8];
    assign hdr_channel = in_data[HEADER_CHANNEL_SHIFT +: 8];
    assign hdr_end     = in_data[HEADER_END_SHIFT];

`ifdef PACKET_DEMUX_CHECK_EN
    assign hdr_ok = ((in_data & HEADER_MASK) == HEADER_TEMPLATE)
                 && ({24'd0, hdr_channel} < 32'(CHANNEL_COUNT))
                 && (hdr_count != 8'd0);
`else
    logic unused_hdr;
    assign hdr_ok     = 1'b1;
    assign unused_hdr = ^{HEADER_MASK, HEADER_TEMPLATE, hdr_channel};
`endif

    assign reg_free = !reg_valid || out_ready[reg_channel];
    assign load     = (state == STATE_PAYLOAD) && in_pop;

    // A zero remaining count in PAYLOAD is a header-only segment: pop nothing, fall back to HEADER.
    always_comb begin
        // NOTE: default assignment first so every path drives in_pop and no latch is inferred.
        in_pop = 1'b0;
        if (state == STATE_HEADER) begin
            in_pop = in_nempty;
        end else begin
            in_pop = in_nempty && reg_free && (remaining != 8'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= STATE_HEADER;
            remaining   <= 8'd0;
            seg_channel <= '0;
            seg_end     <= 1'b0;
        end else if (state == STATE_HEADER) begin
            if (in_nempty && hdr_ok) begin
                seg_channel <= hdr_channel[CH_W-1:0];
                remaining   <= hdr_count;
                seg_end     <= hdr_end;
                state       <= STATE_PAYLOAD;
            end
        end else begin
            if (remaining == 8'd0) begin
                state <= STATE_HEADER;
            end else if (in_pop) begin
                remaining <= remaining - 8'd1;
                if (remaining == 8'd1) begin
                    state <= STATE_HEADER;
                end
            end
        end
    end

    // Load and drain may coincide; the load wins, giving one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_valid   <= 1'b0;
            reg_end     <= 1'b0;
            reg_channel <= '0;
            reg_data    <= '0;
        end else if (load) begin
            reg_valid   <= 1'b1;
            reg_end     <= seg_end && (remaining == 8'd1);
            reg_channel <= seg_channel;
            reg_data    <= in_data;
        end else if (reg_valid && out_ready[reg_channel]) begin
            reg_valid <= 1'b0;
            reg_end   <= 1'b0;
        end
    end

    always_comb begin
        out_valid = '0;
        out_end   = '0;
        if (reg_valid) begin
            out_valid[reg_channel] = 1'b1;
            out_end[reg_channel]   = reg_end;
        end
    end

    assign out_data = reg_data;

`ifdef PACKET_DEMUX_CHECK_EN
    logic [15:0] err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 16'd0;
        end else if ((state == STATE_HEADER) && in_nempty && !hdr_ok
                     && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 16'd0;
`endif

endmodule
